// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler
// Raster timing generator for one HDMI/DVI link. Tracks the (h, v) position,
// decides which period the TMDS encoders are in (control, preamble, guard band
// or active video), and issues pixel fetch requests one cycle ahead of video.
// All outputs are registered and describe the position held in the counters.

module hdmi_period_scheduler #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter bit HDMI_MODE = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  output logic                        o_blanking,
  output logic [1:0]                  o_ctrl_ch0,
  output logic [1:0]                  o_ctrl_ch1,
  output logic [1:0]                  o_ctrl_ch2,
  output logic                        o_de,
  output logic                        o_guard,
  output logic                        o_guard_tmds,
  output logic                        o_pix_req,
  output logic [$clog2(H_ACTIVE)-1:0] o_x,
  output logic [$clog2(V_ACTIVE)-1:0] o_y,
  output logic                        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_BP_BEG    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_PRE_BEG   = HW'(H_TOTAL - 10);
  localparam logic [HW-1:0] H_GUARD_BEG = HW'(H_TOTAL - 2);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [2:0] {
    ST_ACTIVE,
    ST_FP,
    ST_SYNC,
    ST_BP,
    ST_PREAMBLE,
    ST_GUARD
  } hstate_t;

  hstate_t       state, state_nxt;
  logic [HW-1:0] h, h_nxt, h_nn;
  logic [VW-1:0] v, v_nxt, v_nn;
  logic          next_line_active;
  logic          pix_req_nxt;

  // Position after this edge (idle when disabled) and the one after that,
  // which is the position a pixel request has to be issued for.
  always_comb begin
    h_nxt = H_ACT_END;
    v_nxt = V_LAST;
    if (i_en) begin
      h_nxt = (h == H_LAST) ? '0 : h + 1'b1;
      v_nxt = v;
      if (h == H_LAST) v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
    end
    h_nn = (h_nxt == H_LAST) ? '0 : h_nxt + 1'b1;
    v_nn = v_nxt;
    if (h_nxt == H_LAST) v_nn = (v_nxt == V_LAST) ? '0 : v_nxt + 1'b1;
    next_line_active = (v_nxt == V_LAST) || ((v_nxt + 1'b1) < V_ACT_END);
    pix_req_nxt = (h_nn < H_ACT_END) && (v_nn < V_ACT_END);
  end

  // Raster position counters; reset parks them on the idle position.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h <= H_ACT_END;
      v <= V_LAST;
    end else begin
      h <= h_nxt;
      v <= v_nxt;
    end
  end

  // Horizontal period state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_FP;
    else          state <= state_nxt;
  end

  // Horizontal period transitions; preamble and guard only lead into an active line.
  always_comb begin
    state_nxt = state;
    if (!i_en) begin
      state_nxt = ST_FP;
    end else begin
      case (state)
        ST_ACTIVE:   if (h_nxt == H_ACT_END) state_nxt = ST_FP;
        ST_FP:       if (h_nxt == H_SYNC_BEG) state_nxt = ST_SYNC;
        ST_SYNC:     if (h_nxt == H_BP_BEG) state_nxt = ST_BP;
        ST_BP: begin
          if (HDMI_MODE && next_line_active && h_nxt == H_PRE_BEG)
            state_nxt = ST_PREAMBLE;
          else if (h_nxt == '0)
            state_nxt = (v_nxt < V_ACT_END) ? ST_ACTIVE : ST_FP;
        end
        ST_PREAMBLE: if (h_nxt == H_GUARD_BEG) state_nxt = ST_GUARD;
        ST_GUARD:    if (h_nxt == '0) state_nxt = ST_ACTIVE;
        default:     state_nxt = ST_FP;
      endcase
    end
  end

  // Encoder-side outputs decoded from the upcoming period and registered with it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_blanking    <= 1'b1;
      o_ctrl_ch0    <= {~VSYNC_POL, ~HSYNC_POL};
      o_ctrl_ch1    <= 2'b00;
      o_de          <= 1'b0;
      o_guard       <= 1'b0;
      o_pix_req     <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_blanking    <= (state_nxt != ST_ACTIVE);
      o_ctrl_ch0[1] <= (v_nxt >= V_SYNC_BEG && v_nxt < V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
      o_ctrl_ch0[0] <= (state_nxt == ST_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      o_ctrl_ch1    <= (state_nxt == ST_PREAMBLE) ? 2'b01 : 2'b00;
      o_de          <= (state_nxt == ST_ACTIVE);
      o_guard       <= (state_nxt == ST_GUARD);
      o_pix_req     <= pix_req_nxt;
      o_x           <= pix_req_nxt ? h_nn[XW-1:0] : '0;
      o_y           <= pix_req_nxt ? v_nn[YW-1:0] : '0;
      o_frame_start <= pix_req_nxt && (h_nn == '0) && (v_nn == '0);
    end
  end

  // Guard flag delayed to line up with the encoder output register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) o_guard_tmds <= 1'b0;
    else          o_guard_tmds <= o_guard;
  end

  // Only the video preamble (CTL0 on channel 1) is ever signalled; channel 2 stays idle.
  assign o_ctrl_ch2 = 2'b00;

endmodule

// File: doc/hdmi_period_scheduler.md
# hdmi_period_scheduler

- Generates raster timing for one HDMI/DVI link.
- Decides, per pixel clock, which period each of the three TMDS encoder channels is in: control, video preamble, video guard band or active video.
- Drives the encoders' control-data and blanking inputs, requests pixels from the frame source, and flags guard-band cycles for the downstream 10-bit mux.
- Sits between the pixel source and the three `tmds_gen` instances.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch; must satisfy H_FP+H_SYNC+H_BP−10 ≥ 12 when HDMI_MODE=1
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33, vertical timing in lines
- HSYNC_POL, 0, 0 = active-low hsync
- VSYNC_POL, 0, 0 = active-low vsync
- HDMI_MODE, 1, 1 = emit preamble and guard bands; 0 = plain DVI

Ports:
- i_clk  in  1  pixel clock; the only clock
- i_rst_n  in  1  synchronous, active-low reset
- i_en  in  1  run raster; low = hold idle
- o_blanking  out  1  to all encoders' i_blanking
- o_ctrl_ch0  out  2  {vsync, hsync}
- o_ctrl_ch1  out  2  {CTL1, CTL0}
- o_ctrl_ch2  out  2  {CTL3, CTL2}
- o_de  out  1  active video on the encoder inputs this cycle
- o_guard  out  1  guard-band cycle, aligned with the encoder inputs
- o_guard_tmds  out  1  o_guard delayed 1 clock, aligned with the encoder outputs
- o_pix_req  out  1  pixel fetch request, one cycle ahead of o_de
- o_x  out  clog2(H_ACTIVE)  column of the requested pixel
- o_y  out  clog2(V_ACTIVE)  row of the requested pixel
- o_frame_start  out  1  one-cycle pulse with the first o_pix_req of a frame

## Operation
- Counters h (0..H_TOTAL−1) and v (0..V_TOTAL−1), where H_TOTAL = sum of the H parameters and V_TOTAL = sum of the V parameters.
- Horizontal order: active [0, H_ACTIVE), then FP, then SYNC, then BP.
- Vertical order: active lines, then FP, SYNC, BP.
- Idle position = (h=H_ACTIVE, v=V_TOTAL−1), i.e. first FP cycle of the last blank line.
- Reset, and any cycle with i_en=0, load the idle position. Deasserting i_en mid-frame aborts immediately.
- Each edge with i_en=1 advances h; v advances on h wrap; v wraps V_TOTAL−1 → 0.
- Horizontal state machine: ACTIVE → FP → SYNC → BP → PREAMBLE → GUARD → ACTIVE.
  - PREAMBLE occupies h ∈ [H_TOTAL−10, H_TOTAL−3].
  - GUARD occupies h ∈ [H_TOTAL−2, H_TOTAL−1].
  - Both are entered only if HDMI_MODE=1 and the next line is active: (v+1) mod V_TOTAL < V_ACTIVE.
  - Otherwise those positions remain BP, and BP also wraps directly to FP on blank lines.
- Outputs are registered and reflect the current position:
  - o_blanking = 0 only in ACTIVE.
  - hsync is at active level in SYNC. vsync is at active level for whole lines v ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), switching at h=0.
  - PREAMBLE: o_ctrl_ch1=2'b01, o_ctrl_ch2=2'b00. All other states drive both to 2'b00.
  - GUARD: o_guard=1, o_blanking=1, o_ctrl_ch1/ch2=2'b00. The downstream mux substitutes guard symbols using o_guard_tmds.
  - o_de=1 only in ACTIVE.
- o_pix_req=1 when the next position is active; o_x/o_y give that position.
  - This is independent of i_en. A request followed by an abort is simply dropped.
- Reset values: o_blanking=1, o_ctrl_ch0={~VSYNC_POL,~HSYNC_POL} (2'b11 by default), o_ctrl_ch1=o_ctrl_ch2=2'b00. All other outputs 0.
- Idle outputs equal the reset values.

## Timing
- Every output except o_guard_tmds appears in the same cycle as its position.
- o_guard_tmds lags o_guard by exactly 1 clock, matching the single register stage in `tmds_gen`.
- After the first edge that samples i_en=1, o_de first rises exactly H_FP+H_SYNC+H_BP−1 clocks later.
- Reset and i_en=0 take effect on the same edge they are sampled. Reset has priority over i_en.
- No state survives an abort; a restart always begins at the idle position.

## Test plan
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=4, H_BP=16, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, giving H_TOTAL=38 and V_TOTAL=8.

1. **Reset:** hold i_rst_n=0 for 3 clocks with i_en=1 → o_blanking=1, o_ctrl_ch0=2'b11, every other output 0, o_guard_tmds=0.
2. **First line:** release reset, i_en=1 → in order:
   - 1 remaining FP cycle;
   - 4 cycles hsync=0 (o_ctrl_ch0=2'b10);
   - 6 BP cycles;
   - 8 cycles with o_ctrl_ch1=2'b01;
   - 2 cycles with o_guard=1;
   - 16 cycles with o_de=1.
   - o_pix_req leads o_de by 1 with o_x=0..15, o_y=0; o_frame_start pulses once with x=0.
   - o_de first rises 21 clocks after the first sampled i_en.
3. **Vertical:**
   - Line 3 ends with no preamble or guard.
   - Line 5 has vsync=0 for all 38 cycles.
   - Line 7 ends with preamble+guard followed by y=0 active video.
   - 1 frame = 304 clocks between o_frame_start pulses.
4. **DVI mode (HDMI_MODE=0):** over a full frame, o_ctrl_ch1 and o_ctrl_ch2 stay 2'b00, and o_guard and o_guard_tmds never assert. o_de timing is identical to scenario 3.
5. **Abort:** drop i_en when o_x=5 → on the next cycle o_de=0, o_blanking=1, o_ctrl_ch0=2'b11. Re-raise i_en → o_de rises 21 clocks later with y=0.
6. **Reset mid-guard:** pulse i_rst_n=0 for 1 clock while o_guard=1 → o_guard=0 on the next cycle and o_guard_tmds=0 one cycle after. Outputs then match scenario 1.
